// File: rtl/apple_pool_if.sv
// rtl/apple_pool_if.sv - game-side bus of the apple pool: heads in, apple cells and grow pulses out
interface apple_pool_if #(
    parameter int N_APPLE  = 3,
    parameter int N_PLAYER = 2,
    parameter int X_W      = 6,
    parameter int Y_W      = 5
);
    logic                      i_enable;
    logic                      i_clear;
    logic [N_PLAYER*6-1:0]     i_head_x;
    logic [N_PLAYER*6-1:0]     i_head_y;
    logic [N_APPLE*X_W-1:0]    o_apple_x;
    logic [N_APPLE*Y_W-1:0]    o_apple_y;
    logic [N_APPLE-1:0]        o_apple_exist;
    logic [N_PLAYER-1:0]       o_add_cube;

    modport master (
        output i_enable, i_clear, i_head_x, i_head_y,
        input  o_apple_x, o_apple_y, o_apple_exist, o_add_cube
    );

    modport slave (
        input  i_enable, i_clear, i_head_x, i_head_y,
        output o_apple_x, o_apple_y, o_apple_exist, o_add_cube
    );
endinterface

// File: rtl/apple_pool.sv
// rtl/apple_pool.sv - apple slots with shared LFSR placer, eat detection and respawn timers
module apple_pool #(
    parameter int          N_APPLE     = 3,
    parameter int          N_PLAYER    = 2,
    parameter int          GRID_W      = 40,
    parameter int          GRID_H      = 30,
    parameter int          X_W         = 6,
    parameter int          Y_W         = 5,
    parameter int          RESPAWN_CYC = 25_000_000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    apple_pool_if.slave bus
);
    localparam int               CNT_W    = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESPAWN_CYC - 1);
    localparam logic [15:0]      LFSR_RST = (SEED == 16'd0) ? 16'd1 : SEED;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_PLACE  = 2'd1,
        S_ACTIVE = 2'd2
    } slot_e;

    slot_e              state_q [N_APPLE];
    slot_e              state_d [N_APPLE];
    logic [CNT_W-1:0]   cnt_q   [N_APPLE];
    logic [CNT_W-1:0]   cnt_d   [N_APPLE];
    logic [X_W-1:0]     ax_q    [N_APPLE];
    logic [X_W-1:0]     ax_d    [N_APPLE];
    logic [Y_W-1:0]     ay_q    [N_APPLE];
    logic [Y_W-1:0]     ay_d    [N_APPLE];
    logic [N_APPLE-1:0] exist_q, exist_d;
    logic [N_PLAYER-1:0] add_q, add_d;
    logic [15:0]        lfsr_q, lfsr_d;

    logic [X_W-1:0]     cand_x;
    logic [Y_W-1:0]     cand_y;
    logic               cand_ok;
    logic               place_taken;
    logic               eaten;

    function automatic logic on_cell(input logic [5:0] hx, input logic [5:0] hy,
                                     input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (16'(hx) == 16'(x)) && (16'(hy) == 16'(y));
    endfunction

    assign cand_x = lfsr_q[X_W-1:0];
    assign cand_y = lfsr_q[X_W+Y_W-1:X_W];
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // A candidate is usable only on the board and away from every head and every live apple.
    always_comb begin
        cand_ok = (32'(cand_x) < 32'(GRID_W)) && (32'(cand_y) < 32'(GRID_H));
        for (int p = 0; p < N_PLAYER; p++) begin
            if (on_cell(bus.i_head_x[6*p +: 6], bus.i_head_y[6*p +: 6], cand_x, cand_y)) begin
                cand_ok = 1'b0;
            end
        end
        for (int k = 0; k < N_APPLE; k++) begin
            if (state_q[k] == S_ACTIVE && ax_q[k] == cand_x && ay_q[k] == cand_y) begin
                cand_ok = 1'b0;
            end
        end
    end

    always_comb begin
        place_taken = 1'b0;
        eaten       = 1'b0;
        add_d       = '0;
        exist_d     = '0;
        for (int k = 0; k < N_APPLE; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            ax_d[k]    = ax_q[k];
            ay_d[k]    = ay_q[k];
            eaten      = 1'b0;
            if (bus.i_clear) begin
                state_d[k] = S_WAIT;
                cnt_d[k]   = '0;
            end else if (bus.i_enable) begin
                case (state_q[k])
                    S_WAIT: begin
                        if (cnt_q[k] == '0) state_d[k] = S_PLACE;
                        else                cnt_d[k]   = cnt_q[k] - CNT_W'(1);
                    end
                    // Only the lowest-indexed placing slot sees this cycle's candidate.
                    S_PLACE: begin
                        if (!place_taken) begin
                            place_taken = 1'b1;
                            if (cand_ok) begin
                                ax_d[k]    = cand_x;
                                ay_d[k]    = cand_y;
                                state_d[k] = S_ACTIVE;
                            end
                        end
                    end
                    S_ACTIVE: begin
                        for (int p = 0; p < N_PLAYER; p++) begin
                            if (!eaten && on_cell(bus.i_head_x[6*p +: 6], bus.i_head_y[6*p +: 6],
                                                  ax_q[k], ay_q[k])) begin
                                eaten    = 1'b1;
                                add_d[p] = 1'b1;
                            end
                        end
                        if (eaten) begin
                            state_d[k] = S_WAIT;
                            cnt_d[k]   = CNT_LOAD;
                        end
                    end
                    default: state_d[k] = S_WAIT;
                endcase
            end
            exist_d[k] = (state_d[k] == S_ACTIVE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q  <= LFSR_RST;
            exist_q <= '0;
            add_q   <= '0;
            for (int k = 0; k < N_APPLE; k++) begin
                state_q[k] <= S_WAIT;
                cnt_q[k]   <= '0;
                ax_q[k]    <= '0;
                ay_q[k]    <= '0;
            end
        end else begin
            lfsr_q  <= lfsr_d;
            exist_q <= exist_d;
            add_q   <= add_d;
            for (int k = 0; k < N_APPLE; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                ax_q[k]    <= ax_d[k];
                ay_q[k]    <= ay_d[k];
            end
        end
    end

    for (genvar k = 0; k < N_APPLE; k++) begin : g_out
        assign bus.o_apple_x[k*X_W +: X_W] = ax_q[k];
        assign bus.o_apple_y[k*Y_W +: Y_W] = ay_q[k];
    end
    assign bus.o_apple_exist = exist_q;
    assign bus.o_add_cube    = add_q;
endmodule

// File: tb/tb_apple_pool.sv
// tb/tb_apple_pool.sv - directed bench for apple_pool on a 40x30 board and a 2x2 rejection board
module tb_apple_pool;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apple_pool_if #(.N_APPLE(3), .N_PLAYER(2), .X_W(6), .Y_W(5)) bus ();
    apple_pool #(.N_APPLE(3), .N_PLAYER(2), .GRID_W(40), .GRID_H(30), .X_W(6), .Y_W(5),
                 .RESPAWN_CYC(8), .SEED(16'hACE1))
        dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    apple_pool_if #(.N_APPLE(3), .N_PLAYER(1), .X_W(1), .Y_W(1)) sbus ();
    apple_pool #(.N_APPLE(3), .N_PLAYER(1), .GRID_W(2), .GRID_H(2), .X_W(1), .Y_W(1),
                 .RESPAWN_CYC(4), .SEED(16'h0000))
        sdut (.i_clk(clk), .i_rst_n(rst_n), .bus(sbus));

    int n_tests = 0;
    int n_fail  = 0;
    bit dup_main = 0, range_main = 0, dup_s = 0, head_s = 0, add_s = 0;

    typedef struct {
        int         h0;
        int         h1;
        logic       en;
        logic       wf;
        logic [1:0] add;
        logic [2:0] ex;
    } vec_t;
    vec_t vec [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [5:0] ax(input int k);
        return bus.o_apple_x[k*6 +: 6];
    endfunction
    function automatic logic [5:0] ay(input int k);
        return {1'b0, bus.o_apple_y[k*5 +: 5]};
    endfunction
    function automatic logic [5:0] sel_x(input int s);
        return (s == 3) ? 6'd0 : ax(s);
    endfunction
    function automatic logic [5:0] sel_y(input int s);
        return (s == 3) ? 6'd0 : ay(s);
    endfunction
    function automatic logic [3:0] s_mask();
        logic [3:0] m = '0;
        for (int k = 0; k < 3; k++)
            if (sbus.o_apple_exist[k]) m[{sbus.o_apple_y[k], sbus.o_apple_x[k]}] = 1'b1;
        return m;
    endfunction

    task automatic heads(input logic [5:0] x0, input logic [5:0] y0,
                         input logic [5:0] x1, input logic [5:0] y1);
        bus.i_head_x = {x1, x0};
        bus.i_head_y = {y1, y0};
    endtask

    task automatic wait_full(input string name);
        int c = 0;
        while (bus.o_apple_exist != 3'b111 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check(name, bus.o_apple_exist, 3'b111);
    endtask

    // Cell invariants watched on every cycle of both boards.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.o_apple_exist[i]) begin
                    if (ax(i) >= 6'd40 || ay(i) >= 6'd30) range_main = 1;
                    for (int j = i + 1; j < 3; j++)
                        if (bus.o_apple_exist[j] && ax(i) == ax(j) && ay(i) == ay(j)) dup_main = 1;
                end
                if (sbus.o_apple_exist[i]) begin
                    if (sbus.o_apple_x[i] && sbus.o_apple_y[i]) head_s = 1;
                    for (int j = i + 1; j < 3; j++)
                        if (sbus.o_apple_exist[j] && sbus.o_apple_x[i] == sbus.o_apple_x[j]
                            && sbus.o_apple_y[i] == sbus.o_apple_y[j]) dup_s = 1;
                end
            end
            if (sbus.o_add_cube != 1'b0) add_s = 1;
        end
    end

    initial begin
        logic [2:0] prev;
        logic [5:0] a1x, a1y, nx, ny;
        int cyc, c, low, pulses, other, bad_order, early, frz_pulse, frz_exist;

        vec[0] = '{3, 3, 1'b1, 1'b1, 2'b00, 3'b111};
        vec[1] = '{1, 1, 1'b1, 1'b0, 2'b01, 3'b101};
        vec[2] = '{3, 3, 1'b1, 1'b0, 2'b00, 3'b101};
        vec[3] = '{0, 2, 1'b1, 1'b1, 2'b11, 3'b010};
        vec[4] = '{3, 3, 1'b1, 1'b0, 2'b00, 3'b010};
        vec[5] = '{0, 3, 1'b0, 1'b1, 2'b00, 3'b111};
        vec[6] = '{3, 2, 1'b0, 1'b0, 2'b00, 3'b111};
        vec[7] = '{0, 3, 1'b1, 1'b0, 2'b01, 3'b110};
        vec[8] = '{0, 3, 1'b1, 1'b0, 2'b00, 3'b110};

        bus.i_enable = 1'b1;
        bus.i_clear  = 1'b0;
        heads(6'd0, 6'd0, 6'd0, 6'd0);
        sbus.i_enable = 1'b1;
        sbus.i_clear  = 1'b0;
        sbus.i_head_x = 6'd1;
        sbus.i_head_y = 6'd1;

        repeat (3) @(negedge clk);
        check("reset exist", bus.o_apple_exist, 3'b000);
        check("reset add", bus.o_add_cube, 2'b00);
        check("reset x", bus.o_apple_x, 18'd0);
        check("reset y", bus.o_apple_y, 15'd0);
        check("reset small exist", sbus.o_apple_exist, 3'b000);
        rst_n = 1'b1;

        // Test 1: placement order and earliest activation after reset.
        @(negedge clk);
        cyc = 1;
        check("edge1 exist", bus.o_apple_exist, 3'b000);
        prev = 3'b000; bad_order = 0; early = 0;
        while (bus.o_apple_exist != 3'b111 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.o_apple_exist != prev) begin
                if (bus.o_apple_exist != {prev[1:0], 1'b1}) bad_order++;
                if ((bus.o_apple_exist[1] && cyc < 3) || (bus.o_apple_exist[2] && cyc < 4)) early++;
                prev = bus.o_apple_exist;
            end
        end
        check("t1 all placed", bus.o_apple_exist, 3'b111);
        check("t1 fill order", bad_order, 0);
        check("t1 earliest edge", early, 0);
        c = 0;
        for (int k = 0; k < 3; k++) if (ax(k) == 0 && ay(k) == 0) c++;
        check("t1 not under head", c, 0);

        // Test 2: single eat, one pulse, respawn gap.
        a1x = ax(1); a1y = ay(1);
        heads(a1x, a1y, 6'd0, 6'd0);
        @(negedge clk);
        check("t2 eat pulse", bus.o_add_cube, 2'b01);
        check("t2 eat exist1", bus.o_apple_exist[1], 1'b0);
        pulses = 1; other = 0; low = 1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            if (bus.o_add_cube == 2'b01) pulses++;
            else if (bus.o_add_cube != 2'b00) other++;
            if (!bus.o_apple_exist[1]) low++;
        end
        heads(6'd0, 6'd0, 6'd0, 6'd0);
        c = 0;
        while (!bus.o_apple_exist[1] && c < 300) begin
            @(negedge clk);
            c++;
            if (!bus.o_apple_exist[1]) low++;
            if (bus.o_add_cube != 2'b00) other++;
        end
        check("t2 pulse count", pulses, 1);
        check("t2 stray pulse", other, 0);
        check("t2 respawned", bus.o_apple_exist[1], 1'b1);
        check("t2 gap at least 9", (low >= 9), 1'b1);
        nx = ax(1); ny = ay(1);
        check("t2 new cell free", ((nx != ax(0) || ny != ay(0)) && (nx != ax(2) || ny != ay(2))
                                   && (nx != 0 || ny != 0)), 1'b1);

        // Tests 3/4 and frozen/sustained heads: one record per clock.
        for (int r = 0; r < 9; r++) begin
            if (vec[r].wf) begin
                bus.i_enable = 1'b1;
                heads(6'd0, 6'd0, 6'd0, 6'd0);
                wait_full($sformatf("vec%0d refill", r));
            end
            heads(sel_x(vec[r].h0), sel_y(vec[r].h0), sel_x(vec[r].h1), sel_y(vec[r].h1));
            bus.i_enable = vec[r].en;
            @(negedge clk);
            check($sformatf("vec%0d add", r), bus.o_add_cube, vec[r].add);
            check($sformatf("vec%0d exist", r), bus.o_apple_exist, vec[r].ex);
        end
        bus.i_enable = 1'b1;
        heads(6'd0, 6'd0, 6'd0, 6'd0);

        // Clear beats a simultaneous eat.
        wait_full("clr prefill");
        heads(ax(0), ay(0), 6'd0, 6'd0);
        bus.i_clear = 1'b1;
        @(negedge clk);
        check("clr add", bus.o_add_cube, 2'b00);
        check("clr exist", bus.o_apple_exist, 3'b000);
        bus.i_clear = 1'b0;
        heads(6'd0, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        check("clr edge1 exist", bus.o_apple_exist, 3'b000);
        wait_full("clr regrow");

        // Test 5: freeze during respawn wait stretches the gap by the frozen cycles.
        heads(ax(0), ay(0), 6'd0, 6'd0);
        @(negedge clk);
        check("t5 eat pulse", bus.o_add_cube, 2'b01);
        low = bus.o_apple_exist[0] ? 0 : 1;
        heads(6'd0, 6'd0, 6'd0, 6'd0);
        bus.i_enable = 1'b0;
        frz_pulse = 0; frz_exist = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_add_cube != 2'b00) frz_pulse++;
            if (bus.o_apple_exist[0]) frz_exist++; else low++;
        end
        bus.i_enable = 1'b1;
        c = 0;
        while (!bus.o_apple_exist[0] && c < 300) begin
            @(negedge clk);
            c++;
            if (!bus.o_apple_exist[0]) low++;
        end
        check("t5 frozen pulse", frz_pulse, 0);
        check("t5 frozen respawn", frz_exist, 0);
        check("t5 respawned", bus.o_apple_exist[0], 1'b1);
        check("t5 gap at least 29", (low >= 29), 1'b1);

        // Test 6: 2x2 board with head on (1,1) fills the other three cells.
        c = 0;
        while (sbus.o_apple_exist != 3'b111 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("t6 initial fill", sbus.o_apple_exist, 3'b111);
        check("t6 initial cells", s_mask(), 4'b0111);
        sbus.i_clear = 1'b1;
        @(negedge clk);
        check("t6 clear exist", sbus.o_apple_exist, 3'b000);
        sbus.i_clear = 1'b0;
        c = 0;
        while (sbus.o_apple_exist != 3'b111 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("t6 refill", sbus.o_apple_exist, 3'b111);
        check("t6 refill cells", s_mask(), 4'b0111);

        check("main duplicate cell", dup_main, 1'b0);
        check("main out of range", range_main, 1'b0);
        check("small duplicate cell", dup_s, 1'b0);
        check("small apple under head", head_s, 1'b0);
        check("small stray pulse", add_s, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
